vc_wrr_scheduler: RTL and testbench

Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmission-layer datapath. Each cycle it picks at most one eligible VC head, pops it, and pushes the word into the destination selected by the word's routing bit, one cycle later. Eligibility is backpressured by the destination almost-full flags. Per-VC weights are programmed during an init phase. The block reports idle/active status.

---
 rtl/vc_sched_pkg.sv | 16 +
 rtl/vc_wrr_scheduler_if.sv | 26 ++
 rtl/wrr_pointer.sv | 70 +++++++
 rtl/vc_wrr_scheduler.sv | 106 ++++++++++
 tb/tb_vc_wrr_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_sched_pkg.sv
// Shared types and constants for the VC weighted round-robin scheduler.
package vc_sched_pkg;

  localparam int unsigned DATA_WIDTH   = 6;
  localparam int unsigned WEIGHT_WIDTH = 4;
  localparam int unsigned VC_BIT       = DATA_WIDTH - 1;
  localparam int unsigned DEST_BIT     = DATA_WIDTH - 2;

  typedef enum logic [1:0] {StReset, StInit, StIdle, StActive} state_e;

  // A zero weight would starve the VC; treat it as a single grant per turn.
  function automatic logic [WEIGHT_WIDTH-1:0] fix_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

endpackage

// File: rtl/vc_wrr_scheduler_if.sv
// VC-FIFO heads and destination-FIFO push side of the scheduler.
interface vc_wrr_scheduler_if #(
  parameter int unsigned data_width = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [data_width-1:0] vc0_data;
  logic [data_width-1:0] vc1_data;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_push;
  logic                  d1_push;
  logic [data_width-1:0] data_out;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );
endinterface

// File: rtl/wrr_pointer.sv
// Current-VC pointer and burst counter; turns an eligibility pair into a one-hot grant.
module wrr_pointer #(
  parameter int unsigned weight_width = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [1:0]              elig,
  input  logic [weight_width-1:0] weight0,
  input  logic [weight_width-1:0] weight1,
  output logic [1:0]              grant
);

  logic                    cur_q, cur_d;
  logic [weight_width-1:0] cnt_q, cnt_d;
  logic                    oth;
  logic [weight_width-1:0] w_cur, w_oth, w_g;
  logic                    g_any, g_vc;
  logic [weight_width:0]   used;

  always_comb begin
    oth   = ~cur_q;
    w_cur = cur_q ? weight1 : weight0;
    w_oth = cur_q ? weight0 : weight1;
    g_any = 1'b0;
    g_vc  = cur_q;
    w_g   = w_cur;
    used  = '0;
    if (en) begin
      if (elig[cur_q] && (cnt_q < w_cur)) begin
        g_any = 1'b1;
        used  = {1'b0, cnt_q} + 1'b1;
      end else if (elig[oth]) begin
        g_any = 1'b1;
        g_vc  = oth;
        w_g   = w_oth;
        used  = (weight_width + 1)'(1);
      end else if (elig[cur_q]) begin
        // Lone eligible VC with an exhausted burst: serve it and hand the turn over.
        g_any = 1'b1;
        used  = {1'b0, w_cur};
      end
    end

    cur_d = cur_q;
    cnt_d = cnt_q;
    if (g_any) begin
      if (used >= {1'b0, w_g}) begin
        cur_d = ~g_vc;
        cnt_d = '0;
      end else begin
        cur_d = g_vc;
        cnt_d = used[weight_width-1:0];
      end
    end

    grant = g_any ? (g_vc ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler moving words from two VC FIFOs into two destination FIFOs.
module vc_wrr_scheduler
  import vc_sched_pkg::*;
#(
  parameter int unsigned data_width   = DATA_WIDTH,
  parameter int unsigned weight_width = WEIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [weight_width-1:0] peso_vc0,
  input  logic [weight_width-1:0] peso_vc1,
  vc_wrr_scheduler_if.master      bus,
  output logic                    idle_out,
  output logic                    active_out
);

  state_e                  state_q;
  logic [weight_width-1:0] w0_q, w1_q;
  logic [1:0]              elig, grant;
  logic                    en, any_grant;
  logic [data_width-1:0]   gdata, data_q;
  logic                    push0_q, push1_q, idle_q, active_q;

  always_comb begin
    elig[0] = !bus.vc0_empty &&
              !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
    elig[1] = !bus.vc1_empty &&
              !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
    // Dropping init in IDLE wins over a grant in the same cycle.
    en        = ((state_q == StIdle) && init) || (state_q == StActive);
    any_grant = |grant;
    gdata     = grant[1] ? bus.vc1_data : bus.vc0_data;
  end

  wrr_pointer #(
    .weight_width(weight_width)
  ) u_wrr_pointer (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .elig   (elig),
    .weight0(w0_q),
    .weight1(w1_q),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StReset;
      w0_q     <= weight_width'(1);
      w1_q     <= weight_width'(1);
      push0_q  <= 1'b0;
      push1_q  <= 1'b0;
      data_q   <= '0;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      push0_q <= any_grant && !gdata[DEST_BIT];
      push1_q <= any_grant && gdata[DEST_BIT];
      if (any_grant) data_q <= gdata;
      case (state_q)
        StReset: begin
          state_q  <= StInit;
          idle_q   <= 1'b0;
          active_q <= 1'b0;
        end
        StInit: begin
          w0_q <= weight_width'(fix_weight(WEIGHT_WIDTH'(peso_vc0)));
          w1_q <= weight_width'(fix_weight(WEIGHT_WIDTH'(peso_vc1)));
          if (init) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end
        end
        StIdle: begin
          if (!init) begin
            state_q <= StInit;
            idle_q  <= 1'b0;
          end else if (any_grant) begin
            state_q  <= StActive;
            idle_q   <= 1'b0;
            active_q <= 1'b1;
          end
        end
        StActive: begin
          if (!any_grant && !push0_q && !push1_q) begin
            state_q  <= StIdle;
            idle_q   <= 1'b1;
            active_q <= 1'b0;
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  assign bus.vc0_pop  = grant[0];
  assign bus.vc1_pop  = grant[1];
  assign bus.d0_push  = push0_q;
  assign bus.d1_push  = push1_q;
  assign bus.data_out = data_q;
  assign idle_out     = idle_q;
  assign active_out   = active_q;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_vc_wrr_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [3:0] peso_vc0 = '0;
  logic [3:0] peso_vc1 = '0;
  logic       idle_out, active_out;

  vc_wrr_scheduler_if #(.data_width(6)) bus ();

  vc_wrr_scheduler #(
    .data_width  (6),
    .weight_width(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .peso_vc0  (peso_vc0),
    .peso_vc1  (peso_vc1),
    .bus       (bus),
    .idle_out  (idle_out),
    .active_out(active_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE; run = grants given in the current turn.
  int         m_state;
  int         m_w[2];
  int         m_cur, m_run;
  bit         m_push0, m_push1, m_idle, m_active;
  logic [5:0] m_data;
  logic [1:0] last_pop;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state  = 0;
    m_w[0]   = 1;
    m_w[1]   = 1;
    m_cur    = 0;
    m_run    = 0;
    m_push0  = 0;
    m_push1  = 0;
    m_idle   = 0;
    m_active = 0;
    m_data   = '0;
  endfunction

  function automatic int model_grant();
    bit e[2];
    if (!(reset && ((m_state == 2 && init) || m_state == 3))) return -1;
    e[0] = !bus.vc0_empty && !(bus.vc0_data[4] ? bus.d1_almost_full : bus.d0_almost_full);
    e[1] = !bus.vc1_empty && !(bus.vc1_data[4] ? bus.d1_almost_full : bus.d0_almost_full);
    if (e[m_cur] && m_run < m_w[m_cur]) return m_cur;
    if (e[1-m_cur]) return 1 - m_cur;
    if (e[m_cur]) return m_cur;
    return -1;
  endfunction

  function automatic void model_step(input int g);
    logic [5:0] word;
    int nxt;
    word = (g == 1) ? bus.vc1_data : bus.vc0_data;
    nxt  = m_state;
    if (g >= 0) begin
      if (g != m_cur) begin
        m_cur = g;
        m_run = 0;
      end
      m_run++;
      if (m_run >= m_w[m_cur]) begin
        m_cur = 1 - m_cur;
        m_run = 0;
      end
    end
    case (m_state)
      0: nxt = 1;
      1: begin
        m_w[0] = (peso_vc0 == 0) ? 1 : int'(peso_vc0);
        m_w[1] = (peso_vc1 == 0) ? 1 : int'(peso_vc1);
        nxt = init ? 2 : 1;
      end
      2: nxt = !init ? 1 : ((g >= 0) ? 3 : 2);
      default: nxt = (g < 0 && !m_push0 && !m_push1) ? 2 : 3;
    endcase
    m_push0 = (g >= 0) && !word[4];
    m_push1 = (g >= 0) && word[4];
    if (g >= 0) m_data = word;
    m_state  = nxt;
    m_idle   = (nxt == 2);
    m_active = (nxt == 3);
  endfunction

  // Called just after an edge with inputs set; compares mid-cycle, then advances one edge.
  task automatic cycle();
    int g;
    logic [11:0] got, exp;
    #3;
    g = model_grant();
    exp = {(g == 1), (g == 0), m_push1, m_push0, m_idle, m_active, m_data};
    got = {bus.vc1_pop, bus.vc0_pop, bus.d1_push, bus.d0_push, idle_out, active_out,
           bus.data_out};
    last_pop = {bus.vc1_pop, bus.vc0_pop};
    chk("cycle_model", got, exp);
    @(posedge clk);
    if (reset) model_step(g);
    else model_reset();
    #1;
  endtask

  task automatic drain();
    bus.vc0_empty = 1'b1;
    bus.vc1_empty = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (idle_out) break;
    end
    chk("drain_idle", idle_out, 1);
    chk("drain_active", active_out, 0);
  endtask

  initial begin
    int p31[8];
    int p20[6];
    int p12[6];
    p31 = '{0, 0, 0, 1, 0, 0, 0, 1};
    p20 = '{0, 0, 1, 0, 0, 1};
    p12 = '{0, 1, 1, 0, 1, 1};
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;
    bus.vc0_data       = '0;
    bus.vc1_data       = '0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    model_reset();

    repeat (3) cycle();
    chk("reset_status", {idle_out, active_out}, 0);
    chk("reset_push", {bus.d1_push, bus.d0_push, bus.data_out}, 0);

    reset    = 1'b1;
    peso_vc0 = 4'd3;
    peso_vc1 = 4'd1;
    cycle();
    cycle();
    chk("init_status", {idle_out, active_out}, 0);
    init = 1'b1;
    cycle();
    chk("idle_after_init", idle_out, 1);

    // Weights 3/1, both VCs loaded with D0-bound words.
    bus.vc0_empty = 1'b0;
    bus.vc1_empty = 1'b0;
    bus.vc0_data  = 6'b000001;
    bus.vc1_data  = 6'b100010;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("wrr31_pop", last_pop, (p31[i] == 0) ? 2'b01 : 2'b10);
      chk("wrr31_push", bus.d0_push, 1);
    end
    chk("wrr31_active", active_out, 1);
    drain();

    // Weight 0 on VC1 behaves as 1.
    init     = 1'b0;
    peso_vc0 = 4'd2;
    peso_vc1 = 4'd0;
    cycle();
    cycle();
    init = 1'b1;
    cycle();
    bus.vc0_empty = 1'b0;
    bus.vc1_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("wrr20_pop", last_pop, (p20[i] == 0) ? 2'b01 : 2'b10);
    end
    drain();

    // D0 backpressure: only the D1-bound VC1 head may go.
    bus.vc0_empty      = 1'b0;
    bus.vc1_empty      = 1'b0;
    bus.vc0_data       = 6'b000101;
    bus.vc1_data       = 6'b010110;
    bus.d0_almost_full = 1'b1;
    cycle();
    chk("bp_pop", last_pop, 2'b10);
    chk("bp_push", {bus.d1_push, bus.d0_push}, 2'b10);
    chk("bp_data", bus.data_out, 6'b010110);
    bus.d0_almost_full = 1'b0;
    bus.vc1_empty      = 1'b1;
    cycle();
    chk("bp_resume_pop", last_pop, 2'b01);
    chk("bp_resume_data", bus.data_out, 6'b000101);

    // Reset with a push in flight.
    reset = 1'b0;
    model_reset();
    #1;
    chk("reset_async_push", {bus.d1_push, bus.d0_push}, 0);
    cycle();
    cycle();
    reset    = 1'b1;
    init     = 1'b0;
    peso_vc0 = 4'd1;
    peso_vc1 = 4'd2;
    cycle();
    cycle();
    init = 1'b1;
    cycle();
    chk("idle_after_reinit", idle_out, 1);
    bus.vc0_empty = 1'b0;
    bus.vc1_empty = 1'b0;
    bus.vc0_data  = 6'b000011;
    bus.vc1_data  = 6'b100111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("wrr12_pop", last_pop, (p12[i] == 0) ? 2'b01 : 2'b10);
    end

    // Random traffic, weights and occasional init drops.
    for (int i = 0; i < 3000; i++) begin
      bus.vc0_empty      = ($urandom_range(0, 3) == 0);
      bus.vc1_empty      = ($urandom_range(0, 3) == 0);
      bus.vc0_data       = 6'($urandom);
      bus.vc1_data       = 6'($urandom);
      bus.d0_almost_full = ($urandom_range(0, 3) == 0);
      bus.d1_almost_full = ($urandom_range(0, 3) == 0);
      init               = ($urandom_range(0, 39) != 0);
      peso_vc0           = 4'($urandom);
      peso_vc1           = 4'($urandom);
      if (i % 500 == 250) begin
        bus.vc0_empty = 1'b1;
        bus.vc1_empty = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
